regfile_sequencer: RTL and testbench

- Initiator-side controller for the 8-entry register file: accepts one 16-bit instruction through a valid/ready handshake, decodes it, and sequences the register-file port (readnum, writenum, write) and the datapath load/select strobes.
- Sits between the instruction source and the regfile/ALU datapath, and owns every register-file access in the Simple RISC Machine.

---
 rtl/regfile_sequencer.sv | 168 ++++++++++++++++
 tb/tb_regfile_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Instruction sequencer for the 8-entry register file: accepts one instruction over valid/ready,
// decodes it and steps the regfile port and datapath strobes through a registered-output Moore FSM.
module regfile_sequencer #(
  parameter int unsigned data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [2:0]            readnum,
  output logic [2:0]            writenum,
  output logic                  write,
  output logic                  loada,
  output logic                  loadb,
  output logic                  loadc,
  output logic                  loads,
  output logic                  asel,
  output logic [1:0]            vsel,
  output logic [1:0]            shift,
  output logic [1:0]            aluop,
  output logic [data_width-1:0] sximm8,
  output logic                  done,
  output logic                  illegal
);

  typedef enum logic [2:0] {
    StWait, StDecode, StGetA, StGetB, StExec, StWriteReg, StWriteImm
  } state_e;

  typedef enum logic [2:0] {
    OpMovImm, OpMovReg, OpAdd, OpCmp, OpAnd, OpMvn, OpIllegal
  } op_e;

  function automatic op_e decode(input logic [4:0] key);
    case (key)
      5'b110_10: return OpMovImm;
      5'b110_00: return OpMovReg;
      5'b101_00: return OpAdd;
      5'b101_01: return OpCmp;
      5'b101_10: return OpAnd;
      5'b101_11: return OpMvn;
      default:   return OpIllegal;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  op_e         op_q, op_d;

  logic [2:0]  readnum_d, writenum_d;
  logic [1:0]  vsel_d, shift_d, aluop_d;
  logic        write_d, loada_d, loadb_d, loadc_d, loads_d, asel_d, done_d, illegal_d;

  assign op_q   = decode(ir_q[15:11]);
  assign op_d   = decode(ir_d[15:11]);
  assign sximm8 = {{(data_width-8){ir_q[7]}}, ir_q[7:0]};

  // Next state, then the outputs of that next state so every strobe leaves a flop.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      StWait: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        unique case (op_q)
          OpMovImm:              state_d = StWriteImm;
          OpAdd, OpCmp, OpAnd:   state_d = StGetA;
          OpMovReg, OpMvn:       state_d = StGetB;
          default:               state_d = StWait;
        endcase
      end
      StGetA:     state_d = StGetB;
      StGetB:     state_d = StExec;
      StExec:     state_d = (op_q == OpCmp) ? StWait : StWriteReg;
      default:    state_d = StWait;
    endcase

    readnum_d  = 3'd0;
    writenum_d = 3'd0;
    vsel_d     = 2'b00;
    shift_d    = 2'b00;
    aluop_d    = 2'b00;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    unique case (state_d)
      StDecode: illegal_d = (op_d == OpIllegal);
      StGetA: begin
        readnum_d = ir_d[10:8];
        loada_d   = 1'b1;
      end
      StGetB: begin
        readnum_d = ir_d[2:0];
        loadb_d   = 1'b1;
      end
      StExec: begin
        loadc_d = 1'b1;
        shift_d = ir_d[4:3];
        aluop_d = (op_d == OpMovReg) ? 2'b00 : ir_d[12:11];
        asel_d  = (op_d == OpMovReg);
        loads_d = (op_d == OpCmp);
        done_d  = (op_d == OpCmp);
      end
      StWriteReg: begin
        writenum_d = ir_d[7:5];
        write_d    = 1'b1;
        done_d     = 1'b1;
      end
      StWriteImm: begin
        writenum_d = ir_d[10:8];
        write_d    = 1'b1;
        vsel_d     = 2'b10;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StWait;
      ir_q        <= 16'd0;
      instr_ready <= 1'b1;
      readnum     <= 3'd0;
      writenum    <= 3'd0;
      vsel        <= 2'b00;
      shift       <= 2'b00;
      aluop       <= 2'b00;
      write       <= 1'b0;
      loada       <= 1'b0;
      loadb       <= 1'b0;
      loadc       <= 1'b0;
      loads       <= 1'b0;
      asel        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      instr_ready <= (state_d == StWait);
      readnum     <= readnum_d;
      writenum    <= writenum_d;
      vsel        <= vsel_d;
      shift       <= shift_d;
      aluop       <= aluop_d;
      write       <= write_d;
      loada       <= loada_d;
      loadb       <= loadb_d;
      loadc       <= loadc_d;
      loads       <= loads_d;
      asel        <= asel_d;
      done        <= done_d;
      illegal     <= illegal_d;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed table, hand-written reset/back-to-back sequences and
// randomized instructions checked cycle by cycle against a per-instruction schedule model.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset, instr_valid, instr_ready;
  logic [15:0] instr;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, done, illegal;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] sximm8;

  regfile_sequencer #(.data_width(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .vsel(vsel), .shift(shift),
    .aluop(aluop), .sximm8(sximm8), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write, loada, loadb, loadc, loads, asel;
    logic [1:0] vsel, shift, aluop;
    logic       done, illegal;
  } obs_t;

  obs_t act;
  assign act = {instr_ready, readnum, writenum, write, loada, loadb, loadc, loads, asel,
                vsel, shift, aluop, done, illegal};

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Expected strobes for each cycle after the accept edge, built from the instruction's class.
  obs_t trace[$];

  function automatic void model(input logic [15:0] ins);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    bit mov_imm, mov_reg, alu, cmp;
    obs_t o;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8]; rd = ins[7:5]; sh = ins[4:3];
    rm  = ins[2:0];
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    alu     = (opc == 3'b101);
    cmp     = alu && (op == 2'b01);
    trace.delete();
    o = '0;
    o.illegal = !(mov_imm || mov_reg || alu);
    trace.push_back(o);
    if (o.illegal) return;
    if (mov_imm) begin
      o = '0; o.write = 1; o.writenum = rn; o.vsel = 2'b10; o.done = 1;
      trace.push_back(o);
      return;
    end
    if (alu && op != 2'b11) begin
      o = '0; o.loada = 1; o.readnum = rn;
      trace.push_back(o);
    end
    o = '0; o.loadb = 1; o.readnum = rm;
    trace.push_back(o);
    o = '0; o.loadc = 1; o.shift = sh; o.aluop = mov_reg ? 2'b00 : op; o.asel = mov_reg;
    o.loads = cmp; o.done = cmp;
    trace.push_back(o);
    if (!cmp) begin
      o = '0; o.write = 1; o.writenum = rd; o.done = 1;
      trace.push_back(o);
    end
  endfunction

  int         got_lat;
  bit         got_write, got_ill;
  logic [2:0] got_wnum;

  // Entered between negedge and posedge of a WAIT cycle; returns likewise.
  task automatic do_instr(input logic [15:0] ins, input bit noise);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    model(ins);
    got_lat = -1; got_write = 0; got_ill = 0; got_wnum = 3'd0;
    for (int i = 0; i < trace.size(); i++) begin
      if (noise) begin
        instr = 16'($urandom);
        instr_valid = 1'($urandom_range(0, 1));
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("cyc%0d_%04h", i + 1, ins), 32'(act), 32'(trace[i]));
      if (act.done && got_lat < 0) got_lat = i + 1;
      if (act.illegal) got_ill = 1;
      if (act.write) begin
        got_write = 1;
        got_wnum = act.writenum;
      end
      if (trace[i].done) check($sformatf("sximm8_%04h", ins), 32'(sximm8),
                               32'({{8{ins[7]}}, ins[7:0]}));
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    @(negedge clk);
    check($sformatf("idle_after_%04h", ins), 32'(act), 32'(idle_obs()));
  endtask

  typedef struct {
    logic [15:0] ins;
    int          lat;
    bit          wr;
    logic [2:0]  wnum;
    bit          ill;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'hD0FD, 2, 1'b1, 3'd0, 1'b0};
    vecs[1] = '{16'hA148, 5, 1'b1, 3'd2, 1'b0};
    vecs[2] = '{16'hAB04, 4, 1'b0, 3'd0, 1'b0};
    vecs[3] = '{16'hC0A7, 4, 1'b1, 3'd5, 1'b0};
    vecs[4] = '{16'h0000, -1, 1'b0, 3'd0, 1'b1};
    vecs[5] = '{16'hB8C3, 4, 1'b1, 3'd6, 1'b0};
    vecs[6] = '{16'hB153, 5, 1'b1, 3'd2, 1'b0};

    reset = 1'b1; instr_valid = 1'b0; instr = 16'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_obs", 32'(act), 32'(idle_obs()));
    check("reset_sximm8", 32'(sximm8), 32'd0);

    foreach (vecs[k]) begin
      do_instr(vecs[k].ins, 1'b0);
      check($sformatf("lat_%04h", vecs[k].ins), 32'(got_lat), 32'(vecs[k].lat));
      check($sformatf("wr_%04h", vecs[k].ins), 32'(got_write), 32'(vecs[k].wr));
      check($sformatf("wnum_%04h", vecs[k].ins), 32'(got_wnum), 32'(vecs[k].wnum));
      check($sformatf("ill_%04h", vecs[k].ins), 32'(got_ill), 32'(vecs[k].ill));
    end

    // Back-to-back with instr_valid held high; second word must be accepted at cycle 5.
    instr = 16'hC0A7; instr_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 5) instr = 16'hD0FD;
      @(negedge clk);
      if (c == 4) begin
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_wnum1", 32'(writenum), 32'd5);
      end
      if (c == 5) check("b2b_ready", 32'(instr_ready), 32'd1);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("b2b_decode_busy", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_done2", 32'({write, writenum, vsel, done}), 32'({1'b1, 3'd0, 2'b10, 1'b1}));
    check("b2b_sximm8", 32'(sximm8), 32'hFFFD);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_idle", 32'(act), 32'(idle_obs()));

    // Reset during GET_B abandons the instruction.
    instr = 16'hA148; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_getb", 32'({loadb, readnum}), 32'({1'b1, 3'd0}));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mid_reset_idle%0d", c), 32'(act), 32'(idle_obs()));
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    do_instr(16'hD0FD, 1'b0);
    check("post_reset_lat", 32'(got_lat), 32'd2);

    // Reset wins over a simultaneous accept.
    instr = 16'hD0FD; instr_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    check("rst_vs_accept", 32'(act), 32'(idle_obs()));
    check("rst_vs_accept_sx", 32'(sximm8), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_vs_accept2", 32'(act), 32'(idle_obs()));

    for (int n = 0; n < 200; n++) begin
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       r[15:11] = 5'b11010;
        1:       r[15:11] = 5'b11000;
        2, 3, 4, 5: r[15:13] = 3'b101;
        default: ;
      endcase
      do_instr(r, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
